// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//
// Small in-order queue of pending register-file writes. A producer offers
// (rd, data) pairs and the queue drains them one per cycle into the register
// file write port whenever that port is not held. Writes to x0 are accepted
// but discarded. Pending entries can optionally be searched by two read
// indices, so a consumer sees the youngest not-yet-written value.
//
// Configuration macro:
//   WBQ_FORWARD_EN  when defined, compiles in the forward lookup on A1/A2.
//                   When undefined, fwd1_*/fwd2_* are tied to zero and the
//                   ports stay present.
//
// Parameters:
//   DEPTH  number of pending entries (power of two, 2..16)
//   XLEN   data word width
//
// Ports:
//   clk                 single clock, all state updates on its rising edge
//   rst                 synchronous active-high reset
//   in_valid/in_rd/in_data  offered write (producer side)
//   in_ready            queue can take an offer; depends on registered state only
//   wb_hold             register file write port unavailable this cycle
//   RegWrite/A3/WD3     register file write port; A3/WD3 always show the head
//   A1, A2              read indices for the forward lookup
//   fwd1_hit/fwd1_data  youngest pending write matching A1 (A1 != 0)
//   fwd2_hit/fwd2_data  youngest pending write matching A2 (A2 != 0)
//   count/empty/full    occupancy

module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in_valid,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    output logic                     in_ready,

    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [4:0]               A3,
    output logic [XLEN-1:0]          WD3,

    input  logic [4:0]               A1,
    input  logic [4:0]               A2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    // Entry storage. Not reset: validity is defined purely by head/count.
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic empty_w;
    logic full_w;
    logic push_hs;   // handshake completes (includes x0 writes)
    logic store_en;  // handshake that actually occupies an entry
    logic retire;    // head entry leaves this cycle

    // ------------------------------------------------------------------
    // Occupancy and handshakes
    // ------------------------------------------------------------------
    always_comb begin
        empty_w  = (count_q == '0);
        full_w   = (count_q == CntW'(DEPTH));
        // Registered state only: no path from in_valid or wb_hold.
        in_ready = !full_w;
        push_hs  = in_valid && in_ready;
        // x0 is hard-wired zero, so its writes are acknowledged and dropped.
        store_en = push_hs && (in_rd != 5'd0);
        retire   = !empty_w && !wb_hold;
    end

    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign RegWrite = retire;

    // Head is presented combinationally; only meaningful while RegWrite=1.
    assign A3  = rd_q[head_q];
    assign WD3 = data_q[head_q];

    // ------------------------------------------------------------------
    // Next-state: pointers wrap naturally since DEPTH is a power of two
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (retire) begin
            head_d = head_q + PtrW'(1);
        end
        if (store_en) begin
            tail_d = tail_q + PtrW'(1);
        end

        unique case ({store_en, retire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Reset wins over a same-cycle push; the slot write is suppressed too so
    // the array never changes while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst && store_en) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Forward lookup
    // ------------------------------------------------------------------
`ifdef WBQ_FORWARD_EN
    logic [PtrW-1:0] fwd_idx;

    // Walk from oldest (head) to youngest; a later match overwrites an
    // earlier one, so the youngest matching entry wins. Only registered
    // entries are searched, so a push in this cycle is not yet visible,
    // while the head retiring this cycle still is.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if ((A1 != 5'd0) && (rd_q[fwd_idx] == A1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[fwd_idx];
                end
                if ((A2 != 5'd0) && (rd_q[fwd_idx] == A2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[fwd_idx];
                end
            end
        end
    end
`else
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;

    logic unused_lookup;
    assign unused_lookup = ^{A1, A2};
`endif

    // ------------------------------------------------------------------
    // Internal consistency checks (simulation only)
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    count_in_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CntW'(DEPTH));

    no_write_when_empty: assert property (@(posedge clk) disable iff (rst)
        empty_w |-> !RegWrite);

    // Distance between pointers must match the occupancy, except when full
    // where both pointers coincide.
    ptr_count_agree: assert property (@(posedge clk) disable iff (rst)
        (tail_q - head_q) == count_q[PtrW-1:0]);

    no_accept_when_full: assert property (@(posedge clk) disable iff (rst)
        full_w |-> !in_ready);
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue. The stimulus process drives
// inputs just after each rising edge and, once the edge that consumes them
// has passed, pushes every write the queue should have stored onto exp_q.
// The monitor samples on the falling edge: it checks occupancy, handshake
// and lookup outputs against exp_q, and pops/compares one entry every time
// the DUT presents RegWrite.

module tb_reg_writeback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [4:0]             in_rd;
    logic [XLEN-1:0]        in_data;
    logic                   in_ready;
    logic                   wb_hold;
    logic                   RegWrite;
    logic [4:0]             A3;
    logic [XLEN-1:0]        WD3;
    logic [4:0]             A1;
    logic [4:0]             A2;
    logic                   fwd1_hit;
    logic [XLEN-1:0]        fwd1_data;
    logic                   fwd2_hit;
    logic [XLEN-1:0]        fwd2_data;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;

    always #5 clk = ~clk;

    reg_writeback_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wb_hold   (wb_hold),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WD3       (WD3),
        .A1        (A1),
        .A2        (A2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    // Pending writes, oldest first: the reference model of the queue.
    wr_t exp_q[$];

    int  vectors     = 0;
    int  miscompares = 0;
    bit  checking    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Youngest pending write to a nonzero index, from the model queue.
    function automatic void model_fwd(input logic [4:0] a, output logic hit,
                                      output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
`ifdef WBQ_FORWARD_EN
        if (a != 5'd0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].rd == a) begin
                    hit  = 1'b1;
                    data = exp_q[i].data;
                end
            end
        end
`endif
    endfunction

    // One clock cycle of stimulus. Called just after a rising edge.
    task automatic step(input bit r, input bit v, input logic [4:0] rd,
                        input logic [XLEN-1:0] d, input bit hold,
                        input logic [4:0] a1, input logic [4:0] a2);
        bit  do_store;
        wr_t wr;
        rst      = r;
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        wb_hold  = hold;
        A1       = a1;
        A2       = a2;
        // Accepted only while not full at the start of the cycle; x0 dropped.
        do_store = !r && v && (exp_q.size() < DEPTH) && (rd != 5'd0);
        wr.rd    = rd;
        wr.data  = d;
        @(posedge clk);
        #1;
        if (r) exp_q.delete();
        else if (do_store) exp_q.push_back(wr);
    endtask

    task automatic idle(input bit hold);
        step(1'b0, 1'b0, 5'd0, '0, hold, 5'd0, 5'd0);
    endtask

    task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] d, input bit hold);
        step(1'b0, 1'b1, rd, d, hold, 5'd0, 5'd0);
    endtask

    // Monitor: compare everything the DUT presents against the model.
    int              mon_n;
    logic            mon_hit;
    logic [XLEN-1:0] mon_data;
    wr_t             mon_head;

    always @(negedge clk) begin
        if (checking) begin
            mon_n = exp_q.size();
            chk("in_ready", 64'(in_ready), 64'(mon_n < DEPTH));
            chk("count", 64'(count), 64'(mon_n));
            chk("empty", 64'(empty), 64'(mon_n == 0));
            chk("full", 64'(full), 64'(mon_n == DEPTH));
            chk("RegWrite", 64'(RegWrite), 64'((mon_n != 0) && !wb_hold));

            model_fwd(A1, mon_hit, mon_data);
            chk("fwd1_hit", 64'(fwd1_hit), 64'(mon_hit));
            chk("fwd1_data", 64'(fwd1_data), 64'(mon_data));
            model_fwd(A2, mon_hit, mon_data);
            chk("fwd2_hit", 64'(fwd2_hit), 64'(mon_hit));
            chk("fwd2_data", 64'(fwd2_data), 64'(mon_data));

            if (RegWrite === 1'b1) begin
                if (mon_n == 0) begin
                    chk("unexpected_write", 64'(1), 64'(0));
                end else begin
                    mon_head = exp_q.pop_front();
                    chk("A3", 64'(A3), 64'(mon_head.rd));
                    chk("WD3", 64'(WD3), 64'(mon_head.data));
                end
            end
        end
    end

    initial begin
        // Reset
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        checking = 1'b1;
        idle(1'b0);

        // Single write, retired the next cycle.
        push(5'd5, 32'hA5A5_A5A5, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Fill under hold, refused 5th offer, ordered drain.
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11), 1'b1);
        push(5'd9, 32'h99, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // x0 write is acknowledged but never stored.
        push(5'd0, 32'hFFFF_FFFF, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Two writes to the same index; lookup must return the younger.
        push(5'd7, 32'h1, 1'b1);
        push(5'd7, 32'h2, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd7);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);

        // Push and retire together at count 2, then wrap the pointers.
        push(5'd10, 32'h100, 1'b1);
        push(5'd11, 32'h101, 1'b1);
        push(5'd12, 32'h102, 1'b0);
        push(5'd13, 32'h103, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) push(5'(1 + i % 31), 32'h1000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Reset with entries pending and an offer in flight.
        for (int i = 0; i < 3; i++) push(5'(20 + i), 32'h200 + 32'(i), 1'b1);
        step(1'b1, 1'b1, 5'd25, 32'h25, 1'b0, 5'd20, 5'd25);
        idle(1'b0);
        idle(1'b0);

        // Randomized traffic with small index range to force collisions.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 150) == 0,
                 ($urandom % 4) != 0,
                 5'($urandom % 8),
                 $urandom,
                 ($urandom % 3) == 0,
                 5'($urandom % 8),
                 5'($urandom % 8));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (exp_q.size() == 0) break;
            idle(1'b0);
        end
        chk("drained", 64'(exp_q.size()), 64'(0));
        idle(1'b0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
